// File: rtl/alu_issue_pkg.sv
// Shared op encoding and FSM state type for the ALU op issuer.
package alu_issue_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        DRIVE = 2'b01,
        RESP  = 2'b10
    } state_e;

endpackage

// File: rtl/alu_issue_stats.sv
// Per-op saturating issue counters with a combinational read mux.
module alu_issue_stats
    import alu_issue_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    input  logic [1:0]       op_i,
    input  logic             clr_i,
    input  logic [1:0]       sel_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];

    // Clear has priority over an accept in the same cycle.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = cnt_q[i];
            if (clr_i) begin
                cnt_d[i] = '0;
            end else if (inc_i && (op_i == 2'(i)) && (cnt_q[i] != '1)) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rst) begin
                cnt_q[i] <= '0;
            end else begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        count_o = '0;
        case (sel_i)
            OP_ADD:  count_o = cnt_q[0];
            OP_SUB:  count_o = cnt_q[1];
            OP_AND:  count_o = cnt_q[2];
            OP_XOR:  count_o = cnt_q[3];
            default: count_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_op_issuer.sv
// Issues one ALU command at a time to the result-mux datapath and returns fout after a settle time.
// Optional per-op issue counters are built when ALU_OP_ISSUER_STATS_EN is defined.
module alu_op_issuer
    import alu_issue_pkg::*;
#(
    parameter int unsigned WIDTH         = 4,
    parameter int          SETTLE_CYCLES = 1,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       selector,
    input  logic [WIDTH-1:0] fout,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic [1:0]       res_op,
    output logic             res_zero,
    input  logic [1:0]       stat_sel,
    input  logic             stat_clr,
    output logic [CNT_W-1:0] stat_count
);

    localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    if (SETTLE_CYCLES < 1) begin : g_bad_settle
        $error("alu_op_issuer: SETTLE_CYCLES must be at least 1");
    end

    state_e           state_q,     state_d;
    logic [SET_W-1:0] cnt_q,       cnt_d;
    logic [WIDTH-1:0] alu_a_q,     alu_a_d;
    logic [WIDTH-1:0] alu_b_q,     alu_b_d;
    logic [1:0]       sel_q,       sel_d;
    logic [WIDTH-1:0] res_data_q,  res_data_d;
    logic [1:0]       res_op_q,    res_op_d;
    logic             res_zero_q,  res_zero_d;
    logic             res_valid_q, res_valid_d;
    logic             accept_c;

    assign cmd_ready = (state_q == IDLE) && !rst;
    assign accept_c  = cmd_valid && cmd_ready;

    // Operands and selector only change on accept, so the datapath stays quiet otherwise.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        sel_d       = sel_q;
        res_data_d  = res_data_q;
        res_op_d    = res_op_q;
        res_zero_d  = res_zero_q;
        res_valid_d = res_valid_q;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    alu_a_d  = cmd_a;
                    alu_b_d  = cmd_b;
                    sel_d    = cmd_op;
                    res_op_d = cmd_op;
                    cnt_d    = SET_W'(SETTLE_CYCLES - 1);
                    state_d  = DRIVE;
                end
            end
            DRIVE: begin
                if (cnt_q == '0) begin
                    res_data_d  = fout;
                    res_zero_d  = (fout == '0);
                    res_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q - SET_W'(1);
                end
            end
            RESP: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            sel_q       <= '0;
            res_data_q  <= '0;
            res_op_q    <= '0;
            res_zero_q  <= 1'b1;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            sel_q       <= sel_d;
            res_data_q  <= res_data_d;
            res_op_q    <= res_op_d;
            res_zero_q  <= res_zero_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign selector  = sel_q;
    assign res_data  = res_data_q;
    assign res_op    = res_op_q;
    assign res_zero  = res_zero_q;
    assign res_valid = res_valid_q;

`ifdef ALU_OP_ISSUER_STATS_EN
    alu_issue_stats #(
        .CNT_W (CNT_W)
    ) u_stats (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (accept_c),
        .op_i    (cmd_op),
        .clr_i   (stat_clr),
        .sel_i   (stat_sel),
        .count_o (stat_count)
    );
`else
    logic unused_stats;
    assign unused_stats = ^{stat_sel, stat_clr};
    assign stat_count   = '0;
`endif

endmodule

// File: tb/tb_alu_op_issuer.sv
// Self-checking bench for alu_op_issuer: behavioural datapath in the loop, arithmetic reference model.
module tb_alu_op_issuer;
    import alu_issue_pkg::*;

    localparam int unsigned W      = 4;
    localparam int unsigned CW     = 2;
    localparam int          SETTLE = 1;
    localparam int          SETTLE3 = 3;

    logic          clk;
    logic          rst, cmd_valid, cmd_ready, res_valid, res_ready, res_zero, stat_clr;
    logic [1:0]    cmd_op, selector, res_op, stat_sel;
    logic [W-1:0]  cmd_a, cmd_b, alu_a, alu_b, fout, res_data;
    logic [CW-1:0] stat_count;

    logic          r_rst, r_cmd_valid, r_cmd_ready, r_res_valid, r_res_ready, r_res_zero, r_stat_clr;
    logic [1:0]    r_cmd_op, r_selector, r_res_op, r_stat_sel;
    logic [W-1:0]  r_cmd_a, r_cmd_b, r_alu_a, r_alu_b, r_fout, r_res_data;
    logic [CW-1:0] r_stat_count;

    int errors = 0;
    int checks = 0;
    int stat_m [4];

    alu_op_issuer #(.WIDTH(W), .SETTLE_CYCLES(SETTLE), .CNT_W(CW)) u_dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .alu_a(alu_a), .alu_b(alu_b), .selector(selector),
        .fout(fout), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_op(res_op), .res_zero(res_zero), .stat_sel(stat_sel), .stat_clr(stat_clr),
        .stat_count(stat_count)
    );

    alu_op_issuer #(.WIDTH(W), .SETTLE_CYCLES(SETTLE3), .CNT_W(CW)) u_dut3 (
        .clk(clk), .rst(r_rst), .cmd_valid(r_cmd_valid), .cmd_ready(r_cmd_ready), .cmd_op(r_cmd_op),
        .cmd_a(r_cmd_a), .cmd_b(r_cmd_b), .alu_a(r_alu_a), .alu_b(r_alu_b), .selector(r_selector),
        .fout(r_fout), .res_valid(r_res_valid), .res_ready(r_res_ready), .res_data(r_res_data),
        .res_op(r_res_op), .res_zero(r_res_zero), .stat_sel(r_stat_sel), .stat_clr(r_stat_clr),
        .stat_count(r_stat_count)
    );

    // Combinational 4-op datapath feeding the result mux.
    function automatic logic [W-1:0] dp(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            2'b00:   return W'(a + b);
            2'b01:   return W'(a - b);
            2'b10:   return a & b;
            default: return a ^ b;
        endcase
    endfunction

    assign fout   = dp(selector, alu_a, alu_b);
    assign r_fout = dp(r_selector, r_alu_a, r_alu_b);

    // Reference result computed with plain integer arithmetic modulo 16.
    function automatic logic [W-1:0] ref_res(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int ai, bi, r;
        ai = int'(a);
        bi = int'(b);
        case (op)
            2'b00:   r = ai + bi;
            2'b01:   r = ai - bi + 16;
            2'b10:   r = ai & bi;
            default: r = ai ^ bi;
        endcase
        return W'(r % 16);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full transaction on u_dut; entered and left at posedge+1 with the DUT idle.
    task automatic run_txn(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input int hold, input bit clr, input bit poke);
        int k;
        logic [W-1:0] e;
        e = ref_res(op, a, b);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        stat_clr  = clr;
        chk("cmd_ready_idle", 32'(cmd_ready), 32'(1));
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        stat_clr  = 1'b0;
        if (clr) begin
            for (int i = 0; i < 4; i++) stat_m[i] = 0;
        end else begin
            stat_m[op] = (stat_m[op] < (1 << CW) - 1) ? stat_m[op] + 1 : (1 << CW) - 1;
        end
        chk("selector", 32'(selector), 32'(op));
        chk("alu_a", 32'(alu_a), 32'(a));
        chk("alu_b", 32'(alu_b), 32'(b));
        chk("cmd_ready_busy", 32'(cmd_ready), 32'(0));
        chk("res_valid_early", 32'(res_valid), 32'(0));
        k = 0;
        while (!res_valid && k < 10) begin
            @(posedge clk); #1;
            k++;
            chk("cmd_ready_drive", 32'(cmd_ready), 32'(0));
        end
        chk("latency", 32'(k), 32'(SETTLE));
        chk("res_data", 32'(res_data), 32'(e));
        chk("res_zero", 32'(res_zero), 32'(e == '0));
        chk("res_op", 32'(res_op), 32'(op));
        for (int i = 0; i < hold; i++) begin
            if (poke) begin
                cmd_valid = 1'b1;
                cmd_op    = 2'($urandom);
                cmd_a     = W'($urandom);
                cmd_b     = W'($urandom);
            end
            @(posedge clk); #1;
            chk("hold_valid", 32'(res_valid), 32'(1));
            chk("hold_data", 32'(res_data), 32'(e));
            chk("hold_ready", 32'(cmd_ready), 32'(0));
            chk("hold_alu_a", 32'(alu_a), 32'(a));
            chk("hold_sel", 32'(selector), 32'(op));
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk("released", 32'(res_valid), 32'(0));
        chk("cmd_ready_after", 32'(cmd_ready), 32'(1));
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
        res_ready = 1'b0; stat_sel = '0; stat_clr = 1'b0;
        r_rst = 1'b1; r_cmd_valid = 1'b0; r_cmd_op = '0; r_cmd_a = '0; r_cmd_b = '0;
        r_res_ready = 1'b0; r_stat_sel = '0; r_stat_clr = 1'b0;
        for (int i = 0; i < 4; i++) stat_m[i] = 0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'(0));
        chk("rst_res_valid", 32'(res_valid), 32'(0));
        chk("rst_res_zero", 32'(res_zero), 32'(1));
        chk("rst_alu_a", 32'(alu_a), 32'(0));
        chk("rst_selector", 32'(selector), 32'(0));
        chk("rst_res_data", 32'(res_data), 32'(0));
        rst = 1'b0;
        r_rst = 1'b0;
        #1;
        chk("idle_cmd_ready", 32'(cmd_ready), 32'(1));

        // Directed cases
        run_txn(OP_ADD, 4'd3, 4'd5, 0, 1'b0, 1'b0);
        run_txn(OP_SUB, 4'd4, 4'd4, 0, 1'b0, 1'b0);
        run_txn(OP_XOR, 4'hA, 4'h5, 0, 1'b0, 1'b0);
        run_txn(OP_AND, 4'hC, 4'hA, 5, 1'b0, 1'b1);
        run_txn(OP_ADD, 4'hF, 4'h1, 0, 1'b0, 1'b0);

        // Randomized transactions
        repeat (25) begin
            run_txn(2'($urandom), W'($urandom), W'($urandom), int'($urandom_range(0, 3)),
                    1'b0, 1'($urandom));
        end

`ifdef ALU_OP_ISSUER_STATS_EN
        for (int s = 0; s < 4; s++) begin
            stat_sel = 2'(s);
            #1;
            chk("stat_random", 32'(stat_count), 32'(stat_m[s]));
        end
        stat_clr = 1'b1;
        @(posedge clk); #1;
        stat_clr = 1'b0;
        for (int i = 0; i < 4; i++) stat_m[i] = 0;
        repeat (5) run_txn(OP_ADD, W'($urandom), W'($urandom), 0, 1'b0, 1'b0);
        repeat (2) run_txn(OP_XOR, W'($urandom), W'($urandom), 0, 1'b0, 1'b0);
        stat_sel = OP_ADD; #1;
        chk("stat_add_sat", 32'(stat_count), 32'(3));
        stat_sel = OP_XOR; #1;
        chk("stat_xor", 32'(stat_count), 32'(2));
        for (int s = 0; s < 4; s++) begin
            stat_sel = 2'(s);
            #1;
            chk("stat_model", 32'(stat_count), 32'(stat_m[s]));
        end
        run_txn(OP_SUB, 4'd1, 4'd1, 0, 1'b1, 1'b0);
        for (int s = 0; s < 4; s++) begin
            stat_sel = 2'(s);
            #1;
            chk("stat_clr_wins", 32'(stat_count), 32'(0));
        end
`else
        for (int s = 0; s < 4; s++) begin
            stat_sel = 2'(s);
            stat_clr = 1'(s);
            #1;
            chk("stat_tied", 32'(stat_count), 32'(0));
        end
        stat_clr = 1'b0;
`endif

        // Reset during DRIVE on the SETTLE_CYCLES=3 instance
        @(posedge clk); #1;
        r_cmd_valid = 1'b1; r_cmd_op = OP_XOR; r_cmd_a = 4'h6; r_cmd_b = 4'h9;
        chk("r_cmd_ready", 32'(r_cmd_ready), 32'(1));
        @(posedge clk); #1;
        r_cmd_valid = 1'b0;
        chk("r_selector", 32'(r_selector), 32'(OP_XOR));
        chk("r_alu_a", 32'(r_alu_a), 32'(4'h6));
        r_rst = 1'b1;
        @(posedge clk); #1;
        chk("r_rst_valid", 32'(r_res_valid), 32'(0));
        chk("r_rst_sel", 32'(r_selector), 32'(0));
        chk("r_rst_alu_a", 32'(r_alu_a), 32'(0));
        chk("r_rst_alu_b", 32'(r_alu_b), 32'(0));
        chk("r_rst_zero", 32'(r_res_zero), 32'(1));
        r_rst = 1'b0;
        r_res_ready = 1'b1;
        #1;
        chk("r_ready_after_rst", 32'(r_cmd_ready), 32'(1));
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("r_no_stale", 32'(r_res_valid), 32'(0));
        end

        // Clean transaction on the SETTLE_CYCLES=3 instance after the aborted one
        r_res_ready = 1'b0;
        r_cmd_valid = 1'b1; r_cmd_op = OP_SUB; r_cmd_a = 4'h2; r_cmd_b = 4'h5;
        @(posedge clk); #1;
        r_cmd_valid = 1'b0;
        k = 0;
        while (!r_res_valid && k < 10) begin
            @(posedge clk); #1;
            k++;
        end
        chk("r_latency", 32'(k), 32'(SETTLE3));
        chk("r_res_data", 32'(r_res_data), 32'(ref_res(OP_SUB, 4'h2, 4'h5)));
        chk("r_res_op", 32'(r_res_op), 32'(OP_SUB));
        r_res_ready = 1'b1;
        @(posedge clk); #1;
        r_res_ready = 1'b0;
        chk("r_released", 32'(r_res_valid), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_op_issuer.md
Name: alu_op_issuer

Overview:
- Upstream control end of the 4-operation ALU result mux.
- Accepts one ALU command per valid/ready handshake and registers operands plus the 2-bit selector toward the datapath (adder/subtractor/and/xor feeding the result mux).
- Waits a fixed settle time, captures the muxed result fout, and returns it on a valid/ready response channel.
- Sits between the instruction/control logic and the combinational ALU datapath.

Parameters:
- WIDTH, 4, operand/result width.
- SETTLE_CYCLES, 1, cycles the selector and operands are held before fout is sampled; legal minimum 1.
- CNT_W, 8, width of each per-op statistics counter.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  issuer can accept a command
- cmd_op  in  2  op code: 00 ADD, 01 SUB, 10 AND, 11 XOR
- cmd_a  in  WIDTH  operand A
- cmd_b  in  WIDTH  operand B
- alu_a  out  WIDTH  registered operand A to the datapath
- alu_b  out  WIDTH  registered operand B to the datapath
- selector  out  2  registered mux select; same encoding as cmd_op
- fout  in  WIDTH  muxed datapath result
- res_valid  out  1  result available
- res_ready  in  1  consumer takes the result
- res_data  out  WIDTH  captured result
- res_op  out  2  op that produced res_data
- res_zero  out  1  res_data == 0
- stat_sel  in  2  op whose counter drives stat_count
- stat_clr  in  1  synchronous clear of all stat counters
- stat_count  out  CNT_W  issue count for stat_sel

Behaviour:
- Clocking and reset: one clock (clk); rst is synchronous and active-high.
- State machine: IDLE, DRIVE, RESP.
- Reset values: state IDLE; alu_a, alu_b, selector, res_data, res_op = 0; res_valid 0; res_zero 1; counters 0.
- cmd_ready = (state==IDLE) && !rst. It is combinational from state; there is no path from cmd_valid to cmd_ready.
- IDLE:
  - On cmd_valid && cmd_ready at edge T: latch cmd_a→alu_a, cmd_b→alu_b, cmd_op→selector and res_op.
  - Load settle counter with SETTLE_CYCLES-1 and go to DRIVE.
- DRIVE:
  - alu_a, alu_b and selector are held stable.
  - Counter decrements each cycle.
  - On the edge where the counter is 0: res_data←fout, res_zero←(fout==0), res_valid←1, go to RESP.
  - Accept-to-res_valid latency = SETTLE_CYCLES+1 edges (2 at default).
- RESP:
  - res_valid, res_data, res_op and res_zero are held stable until res_ready.
  - On res_valid && res_ready: res_valid←0, go to IDLE. cmd_ready rises the following cycle.
  - There is no accept in the same cycle as a response handshake. Peak throughput is one command per SETTLE_CYCLES+2 cycles.
- Operand/selector hold: alu_a, alu_b and selector keep their last values in IDLE and RESP so the datapath does not toggle.
- Ignored inputs: cmd_valid outside IDLE and res_ready outside RESP have no effect. fout is sampled only on the capture edge.
- Reset mid-operation (DRIVE or RESP): the in-flight command and result are discarded. All outputs return to reset values on the next edge. No res_valid is produced for the discarded command.
- Widths: results are WIDTH bits, no carry/borrow outputs; wrap-around is the datapath's responsibility.
- Invalid configuration: SETTLE_CYCLES < 1 triggers a simulation-time $error.

Optional Feature:
- Macro: ALU_OP_ISSUER_STATS_EN.
- Defined:
  - Four CNT_W counters, one per op. The counter for cmd_op increments on each command accept and saturates at 2^CNT_W-1.
  - rst or stat_clr zeroes all counters. If stat_clr and an accept occur in the same cycle, clear wins.
  - stat_count = counter[stat_sel], combinational.
- Not defined: the ports still exist, stat_count is tied 0, and stat_sel/stat_clr are ignored.

Decomposition:
- Package alu_issue_pkg: op encoding constants (OP_ADD=2'b00, OP_SUB=2'b01, OP_AND=2'b10, OP_XOR=2'b11) and the state enum (IDLE/DRIVE/RESP).
- Sub-module alu_issue_stats: the four saturating counters and the read mux. It is instantiated only under ALU_OP_ISSUER_STATS_EN.

Test Plan (bench closes the loop with a behavioural 4-op datapath plus the result mux, WIDTH=4):
- ADD 3,5 with res_ready=1, SETTLE_CYCLES=1 → selector=00 one edge after accept; res_valid 2 edges after accept; res_data=8, res_zero=0, res_op=00; cmd_ready high again 1 cycle after the response handshake.
- SUB 4,4 then XOR 0xA,0x5 back-to-back → res_data=0 with res_zero=1, then res_data=0xF with res_zero=0; cmd_ready is never high during DRIVE/RESP.
- Backpressure: AND 0xC,0xA with res_ready=0 for 5 cycles → res_valid=1 and res_data=0x8 stable for all 5 cycles; cmd_valid pulses in that window are not accepted; the result is released on the first cycle res_ready=1.
- Reset in DRIVE (SETTLE_CYCLES=3, rst asserted 1 cycle after accept) → next edge: res_valid=0, selector=0, alu_a/alu_b=0, cmd_ready=1 after rst drops; no stale response appears.
- Wrap-around: ADD 0xF,0x1 → res_data=0x0, res_zero=1.
- STATS_EN, CNT_W=2:
  - 5 ADDs, 2 XORs → stat_sel=00 reads 3 (saturated), stat_sel=11 reads 2.
  - stat_clr asserted together with an accept → all counters read 0.
